ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
//  Sequences an iterative 32x32 multiply/divide resource beside the EX-stage ALU and owns the HI/LO registers.
//  Issues MULT/MULTU/DIV/DIVU, serves MTHI/MTLO/MFHI/MFLO, and stalls the pipeline while the unit is busy.
//  MF results feed the EX->MEM result mux alongside ALUOut.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
//  CNT_W   6   iteration counter width, >= clog2(WIDTH+1)
// PORTS
//  clk                 in   1      single clock, rising edge
//  nrst                in   1      synchronous reset, active-low
//  i_EX_ctrl_MDOp      in   4      0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO; 9-15 = NONE
//  i_EX_ctrl_Flush     in   1      EX instruction squashed; MDOp treated as NONE this cycle
//  i_EX_data_RSData    in   WIDTH  rs operand (multiplicand/dividend, MT source)
//  i_EX_data_RTData    in   WIDTH  rt operand (multiplier/divisor)
//  o_HZ_ctrl_Stall     out  1      hold IF/ID/EX, bubble into MEM (combinational)
//  o_MEM_data_MDOut    out  WIDTH  HI (MFHI) or LO (MFLO), else 0 (combinational)
//  o_MEM_data_DivZero  out  1      one-cycle pulse: DIV/DIVU issued with rt==0
//  o_MD_busy           out  1      iteration in progress
//  o_HI / o_LO         out  WIDTH  architectural HI/LO (debug/trace)
// BEHAVIOUR
//  Reset (nrst=0 at an edge): state IDLE, HI=LO=0, counter=0, busy=0, DivZero=0; aborts any op mid-iteration, no HI/LO write.
//  op_v = (MDOp in 1..8) & ~Flush. Stall = op_v & busy (any MD op, including MF/MT, waits for busy to drop).
//  States: IDLE -> ITER (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE, op_v & MULT/MULTU/DIV/DIVU (rt!=0 for div) at edge E0: latch |rs|,|rt| (raw for U ops), result signs, cnt=WIDTH, ->ITER.
//  ITER: one bit per cycle; shift-add multiply or restoring divide on magnitudes; cnt-1 each edge; cnt==1 edge -> FIX.
//  FIX: negate product if signs differ (signed ops); quotient negated if signs differ, remainder takes dividend sign.
//   HI/LO written at the FIX exit edge = E0+WIDTH+1; busy=1 for exactly WIDTH+1 cycles after E0.
//  MULT*: {HI,LO} = 2*WIDTH product. DIV*: LO = quotient (trunc toward zero), HI = remainder.
//  DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
//  DIV*/DIVU with rt==0: no iteration, stay IDLE, HI/LO unchanged, DivZero=1 the cycle after E0.
//  MTHI/MTLO in IDLE: HI/LO <= rs at that edge; visible to an MF in the next cycle.
//  MFHI/MFLO in IDLE: MDOut = current HI/LO same cycle, no stall.
//  Stalled op: EX holds it; re-presented each cycle; accepted on the first cycle busy==0 (cycle after the FIX edge), sees new HI/LO.
//  Flush never aborts an in-flight iteration; it only qualifies the current-cycle op.
//  Flush and op in the same cycle: op ignored, no stall, no state change.
//  Counter never wraps: loaded only in IDLE, ITER exits at cnt==1.
// TESTING
//  MULT rs=0xFFFFFFFF rt=2 -> busy 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=1, LO=0xFFFFFFFE.
//  DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=7 rt=2 -> LO=3, HI=1; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  DIVU rt=0 with HI=5, LO=6 -> DivZero pulses 1 cycle, busy stays 0, HI=5, LO=6.
//  MULT then MFLO next cycle -> Stall high 33 cycles; MFLO returns the new LO on the first unstalled cycle; back-to-back MULT also stalls.
//  MTHI rs=0x1234 then MFHI next cycle -> MDOut=0x1234, Stall never asserted; MTLO with Flush=1 -> LO unchanged.
//  Reset pulse at iteration 10 of a DIV -> busy=0, HI=LO=0 next cycle; a following MULT 3*4 -> LO=12, HI=0.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs a one-bit-per-cycle
// shift-add multiply or restoring divide, and stalls the pipeline while busy.
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [3:0]       i_EX_ctrl_MDOp,
  input  logic             i_EX_ctrl_Flush,
  input  logic [WIDTH-1:0] i_EX_data_RSData,
  input  logic [WIDTH-1:0] i_EX_data_RTData,
  output logic             o_HZ_ctrl_Stall,
  output logic [WIDTH-1:0] o_MEM_data_MDOut,
  output logic             o_MEM_data_DivZero,
  output logic             o_MD_busy,
  output logic [WIDTH-1:0] o_HI,
  output logic [WIDTH-1:0] o_LO
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX
  } state_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             op_v, busy;
  logic             is_md, is_dv, sgn;
  logic             rt_zero, start;
  logic             rs_s, rt_s;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign op_v = (i_EX_ctrl_MDOp >= OP_MULT)
             && (i_EX_ctrl_MDOp <= OP_MFLO)
             && !i_EX_ctrl_Flush;
  assign busy = (state_q != S_IDLE);

  assign is_md = (i_EX_ctrl_MDOp >= OP_MULT)
              && (i_EX_ctrl_MDOp <= OP_DIVU);
  assign is_dv = (i_EX_ctrl_MDOp == OP_DIV)
              || (i_EX_ctrl_MDOp == OP_DIVU);
  assign sgn   = (i_EX_ctrl_MDOp == OP_MULT)
              || (i_EX_ctrl_MDOp == OP_DIV);

  assign rt_zero = (i_EX_data_RTData == '0);
  assign start   = op_v && !busy && is_md
                && !(is_dv && rt_zero);
  assign dz_d    = op_v && !busy && is_dv && rt_zero;

  assign rs_s   = sgn && i_EX_data_RSData[WIDTH-1];
  assign rt_s   = sgn && i_EX_data_RTData[WIDTH-1];
  assign rs_mag = rs_s ? -i_EX_data_RSData
                       : i_EX_data_RSData;
  assign rt_mag = rt_s ? -i_EX_data_RTData
                       : i_EX_data_RTData;

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ITER;
      S_ITER: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_HZ_ctrl_Stall    = op_v && busy;
    o_MD_busy          = busy;
    o_MEM_data_DivZero = dz_q;
    o_HI               = hi_q;
    o_LO               = lo_q;
    o_MEM_data_MDOut   = '0;
    unique case (1'b1)
      op_v && (i_EX_ctrl_MDOp == OP_MFHI):
        o_MEM_data_MDOut = hi_q;
      op_v && (i_EX_ctrl_MDOp == OP_MFLO):
        o_MEM_data_MDOut = lo_q;
      default: ;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    sum    = {1'b0, acc_q} + {1'b0, b_q};
    trial  = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    prod   = {acc_q, a_q};
    if (neg_q) prod = -prod;
    quo    = neg_q  ? -a_q   : a_q;
    rem    = rneg_q ? -acc_q : acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = '0;
          a_d    = is_dv ? rs_mag : rt_mag;
          b_d    = is_dv ? rt_mag : rs_mag;
          cnt_d  = CNT_W'(WIDTH);
          div_d  = is_dv;
          neg_d  = rs_s ^ rt_s;
          rneg_d = rs_s;
        end
        if (op_v && (i_EX_ctrl_MDOp == OP_MTHI))
          hi_d = i_EX_data_RSData;
        if (op_v && (i_EX_ctrl_MDOp == OP_MTLO))
          lo_d = i_EX_data_RSData;
      end
      S_ITER: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (div_q) begin
          // restoring step: keep the trial difference only when it did not borrow
          if (!trial[WIDTH]) begin
            acc_d = trial[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end else if (a_q[0]) begin
          acc_d = sum[WIDTH:1];
          a_d   = {sum[0], a_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[WIDTH-1:1]};
          a_d   = {acc_q[0], a_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (div_q) begin
          lo_d = quo;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: arithmetic reference model checked every cycle,
// plus literal expectations for the headline cases.
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        nrst;
  logic [3:0]  MDOp;
  logic        Flush;
  logic [31:0] RS, RT;
  logic        Stall, DivZero, Busy;
  logic [31:0] MDOut, HI, LO;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .i_EX_ctrl_MDOp     (MDOp),
    .i_EX_ctrl_Flush    (Flush),
    .i_EX_data_RSData   (RS),
    .i_EX_data_RTData   (RT),
    .o_HZ_ctrl_Stall    (Stall),
    .o_MEM_data_MDOut   (MDOut),
    .o_MEM_data_DivZero (DivZero),
    .o_MD_busy          (Busy),
    .o_HI               (HI),
    .o_LO               (LO)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: remaining busy cycles and pending result
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          m_left = 0;
  bit          m_dz = 0;
  logic [63:0] mp;
  longint      ma, mb, mq, mr;

  function automatic bit opv();
    return (MDOp >= 1) && (MDOp <= 8) && !Flush;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_dz = 0;
    end else begin
      m_dz = opv() && m_left == 0 && (MDOp == 3 || MDOp == 4) && RT == 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo;
        end
      end else if (opv()) begin
        case (MDOp)
          4'd1: begin
            mp = {{32{RS[31]}}, RS} * {{32{RT[31]}}, RT};
            p_hi = mp[63:32]; p_lo = mp[31:0]; m_left = 33;
          end
          4'd2: begin
            mp = {32'd0, RS} * {32'd0, RT};
            p_hi = mp[63:32]; p_lo = mp[31:0]; m_left = 33;
          end
          4'd3, 4'd4: if (RT != 0) begin
            if (MDOp == 3) begin
              ma = longint'($signed(RS)); mb = longint'($signed(RT));
            end else begin
              ma = longint'({32'd0, RS}); mb = longint'({32'd0, RT});
            end
            mq = ma / mb; mr = ma % mb;
            p_lo = mq[31:0]; p_hi = mr[31:0]; m_left = 33;
          end
          4'd5: m_hi = RS;
          4'd6: m_lo = RS;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit st;
      logic [31:0] md;
      st = opv() && m_left > 0;
      check("busy", {31'd0, Busy}, {31'd0, m_left > 0});
      check("stall", {31'd0, Stall}, {31'd0, st});
      check("divzero", {31'd0, DivZero}, {31'd0, m_dz});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      if (!st) begin
        md = 0;
        if (opv() && MDOp == 7) md = m_hi;
        if (opv() && MDOp == 8) md = m_lo;
        check("mdout", MDOut, md);
      end
    end
  end

  // Present an op until accepted; report stall cycles and MDOut seen on accept
  task automatic issue(input logic [3:0] op, input logic fl,
                       input logic [31:0] rs, input logic [31:0] rt,
                       output int nst, output logic [31:0] md);
    bit st;
    nst = 0;
    md = 0;
    MDOp = op; Flush = fl; RS = rs; RT = rt;
    forever begin
      @(negedge clk);
      st = Stall;
      md = MDOut;
      @(posedge clk); #1;
      if (!st) break;
      nst++;
      if (nst > 200) begin
        errors++;
        $display("FAIL issue_timeout: stalled %0d cycles", nst);
        break;
      end
    end
    MDOp = 0; Flush = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL busy_timeout: busy %0d cycles", n);
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  vec_t tbl[8] = '{
    '{4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE},
    '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{4'd4, 32'd7,        32'd2, 32'h00000001, 32'h00000003},
    '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000},
    '{4'd1, 32'h00010000, 32'h00010000, 32'h1, 32'h0},
    '{4'd3, 32'd100,      32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2},
    '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1}
  };

  initial begin
    int n, n2;
    logic [31:0] md;
    nrst = 0; MDOp = 0; Flush = 0; RS = 0; RT = 0;
    repeat (2) @(posedge clk);
    #1; nrst = 1; chk_en = 1;
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", {31'd0, Busy}, 32'h0);

    foreach (tbl[i]) begin
      issue(tbl[i].op, 1'b0, tbl[i].rs, tbl[i].rt, n, md);
      wait_idle(n);
      check($sformatf("busy_len%0d", i), n, 33);
      check($sformatf("vec_hi%0d", i), HI, tbl[i].hi);
      check($sformatf("vec_lo%0d", i), LO, tbl[i].lo);
    end

    issue(4'd5, 1'b0, 32'd5, 32'd0, n, md);
    issue(4'd6, 1'b0, 32'd6, 32'd0, n, md);
    issue(4'd4, 1'b0, 32'd9, 32'd0, n, md);
    @(negedge clk);
    check("dz_pulse", {31'd0, DivZero}, 32'd1);
    check("dz_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    check("dz_drop", {31'd0, DivZero}, 32'd0);
    check("dz_hi", HI, 32'd5);
    check("dz_lo", LO, 32'd6);

    issue(4'd1, 1'b0, 32'd3, 32'h12345678, n, md);
    issue(4'd8, 1'b0, 32'd0, 32'd0, n, md);
    check("mflo_stall", n, 33);
    check("mflo_val", md, 32'h369D0368);
    issue(4'd2, 1'b0, 32'd10, 32'd10, n, md);
    issue(4'd2, 1'b0, 32'd7, 32'd6, n2, md);
    check("b2b_stall", n2, 33);
    MDOp = 4'd7; Flush = 1'b1;
    repeat (5) @(posedge clk);
    #1; MDOp = 0; Flush = 0;
    wait_idle(n);
    check("b2b_lo", LO, 32'd42);

    issue(4'd5, 1'b0, 32'h1234, 32'd0, n, md);
    issue(4'd7, 1'b0, 32'd0, 32'd0, n, md);
    check("mfhi_stall", n, 0);
    check("mfhi_val", md, 32'h1234);
    issue(4'd6, 1'b1, 32'hDEAD, 32'd0, n, md);
    @(negedge clk);
    check("mtlo_flush", LO, 32'd42);

    issue(4'd3, 1'b0, 32'd100, 32'd7, n, md);
    repeat (10) @(posedge clk);
    #1; nrst = 0;
    @(posedge clk);
    #1; nrst = 1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    issue(4'd1, 1'b0, 32'd3, 32'd4, n, md);
    wait_idle(n);
    check("post_lo", LO, 32'd12);
    check("post_hi", HI, 32'd0);

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
